fp_cmp_issue_ctrl: RTL and testbench

//  Issue/response shell around the FP equality comparator (FPCompareEqWrapper) in the FPU.

---
 rtl/fp_cmp_pkg.sv | 19 +
 rtl/fp_cmp_resp_fifo.sv | 64 ++++++
 rtl/fp_cmp_issue_ctrl.sv | 145 ++++++++++++++
 tb/tb_fp_cmp_issue_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_cmp_pkg.sv
// Shared types for the FP compare issue/response shell.
//   fp_cmp_op_t   : requested comparison (EQ or NE)
//   fp_cmp_resp_t : buffered response {tag, result}
package fp_cmp_pkg;

    // Must match the TAG_W parameter of fp_cmp_issue_ctrl; the top checks this.
    localparam int FP_CMP_TAG_W = 5;

    typedef enum logic {
        CMP_EQ = 1'b0,
        CMP_NE = 1'b1
    } fp_cmp_op_t;

    typedef struct packed {
        logic [FP_CMP_TAG_W-1:0] tag;
        logic                    result;
    } fp_cmp_resp_t;

endpackage

// File: rtl/fp_cmp_resp_fifo.sv
// Response FIFO of fp_cmp_resp_t entries.
//   clock, reset : clock, asynchronous active-low reset
//   push, din    : write an entry (caller guarantees space via credits)
//   pop          : consume the head (ignored when empty)
//   dout, valid  : head entry and its valid flag (no bypass from din)
//   count        : current occupancy
// Pointers wrap explicitly at DEPTH-1 so DEPTH need not be a power of two.
module fp_cmp_resp_fifo
    import fp_cmp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  fp_cmp_resp_t                 din,
    input  logic                         pop,
    output fp_cmp_resp_t                 dout,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fp_cmp_resp_t     mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] cnt;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_ok = pop & (cnt != '0);

    // Push while full is only legal together with a pop; the slot being
    // written is the one being freed, so no special case is needed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= ptr_inc(wptr);
            end
            if (pop_ok) rptr <= ptr_inc(rptr);
            unique case ({push, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = mem[rptr];
    assign valid = (cnt != '0);
    assign count = cnt;

endmodule

// File: rtl/fp_cmp_issue_ctrl.sv
// Issue/response shell around the fixed-latency FP equality comparator.
//   clock, reset            : clock, asynchronous active-low reset
//   req_valid/req_ready     : request handshake; req_ready is registered
//   req_op, req_tag         : EQ/NE select and tag returned with the result
//   req_a, req_b            : IEEE-754 single operands
//   cmp_a, cmp_b            : registered operands to the comparator
//   cmp_q                   : comparator equal flag, LATENCY cycles after cmp_a/cmp_b
//   resp_valid/resp_ready   : response handshake from the FIFO head
//   resp_tag, resp_result   : head tag and cmp_q ^ op
// A credit counter reserves a FIFO slot at accept time, so the non-stallable
// comparator output always has somewhere to land.
module fp_cmp_issue_ctrl
    import fp_cmp_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int TAG_W   = FP_CMP_TAG_W,
    parameter int DEPTH   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [31:0]       req_a,
    input  logic [31:0]       req_b,
    output logic [31:0]       cmp_a,
    output logic [31:0]       cmp_b,
    input  logic              cmp_q,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              resp_result
);

    localparam int CW = $clog2(DEPTH + 1);

    if (LATENCY < 1 || DEPTH < 1) begin : g_param_err
        $error("fp_cmp_issue_ctrl: LATENCY and DEPTH must both be >= 1");
    end
    if (TAG_W != FP_CMP_TAG_W) begin : g_tag_err
        $error("fp_cmp_issue_ctrl: TAG_W must equal fp_cmp_pkg::FP_CMP_TAG_W");
    end

    logic                        accept;
    logic                        pop;
    logic [CW-1:0]               credits;
    logic [CW-1:0]               credits_nxt;

    // Stage 0 is loaded alongside cmp_a/cmp_b; stage LATENCY lines up with cmp_q.
    logic [LATENCY:0]            vld_pipe;
    logic [LATENCY:0][TAG_W-1:0] tag_pipe;
    logic [LATENCY:0]            op_pipe;

    fp_cmp_op_t                  out_op;
    fp_cmp_resp_t                push_data;
    fp_cmp_resp_t                head;
    logic [CW-1:0]               fifo_count;

    assign accept = req_valid & req_ready;
    assign pop    = resp_valid & resp_ready;

    always_comb begin
        credits_nxt = credits;
        unique case ({accept, pop})
            2'b10:   credits_nxt = credits - 1'b1;
            2'b01:   credits_nxt = credits + 1'b1;
            default: credits_nxt = credits;
        endcase
    end

    // req_ready is a flop of (credits_nxt != 0): no combinational path from resp_ready.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            credits   <= CW'(DEPTH);
            req_ready <= 1'b1;
        end else begin
            credits   <= credits_nxt;
            req_ready <= (credits_nxt != '0);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmp_a <= '0;
            cmp_b <= '0;
        end else if (accept) begin
            cmp_a <= req_a;
            cmp_b <= req_b;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
            op_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[LATENCY-1:0], accept};
            tag_pipe <= {tag_pipe[LATENCY-1:0], req_tag};
            op_pipe  <= {op_pipe[LATENCY-1:0], req_op};
        end
    end

    // cmp_q is only meaningful when the aligned stage is valid; stale q after
    // reset is ignored because the valids are cleared.
    assign out_op           = fp_cmp_op_t'(op_pipe[LATENCY]);
    assign push_data.tag    = tag_pipe[LATENCY];
    assign push_data.result = cmp_q ^ (out_op == CMP_NE);

    fp_cmp_resp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (vld_pipe[LATENCY]),
        .din   (push_data),
        .pop   (pop),
        .dout  (head),
        .valid (resp_valid),
        .count (fifo_count)
    );

    assign resp_tag    = head.tag;
    assign resp_result = head.result;

`ifndef SYNTHESIS
    int inflight;

    always_comb begin
        inflight = 0;
        for (int i = 0; i <= LATENCY; i++) inflight += int'(vld_pipe[i]);
    end

    // Every accepted request owns exactly one credit until it is popped.
    always_ff @(posedge clock) begin
        if (reset) begin
            assert (int'(credits) + inflight + int'(fifo_count) == DEPTH)
            else $error("fp_cmp_issue_ctrl: credit invariant broken (credits=%0d inflight=%0d count=%0d)",
                        credits, inflight, fifo_count);
        end
    end
`endif

endmodule

// File: tb/tb_fp_cmp_issue_ctrl.sv
module tb_fp_cmp_issue_ctrl;
    import fp_cmp_pkg::*;

    localparam int LAT = 1;
    localparam int TW  = 5;
    localparam int DEP = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_op = 1'b0;
    logic [TW-1:0] req_tag = '0;
    logic [31:0]   req_a = '0;
    logic [31:0]   req_b = '0;
    logic [31:0]   cmp_a;
    logic [31:0]   cmp_b;
    logic          cmp_q;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [TW-1:0] resp_tag;
    logic          resp_result;

    always #5 clock = ~clock;

    fp_cmp_issue_ctrl #(.LATENCY(LAT), .TAG_W(TW), .DEPTH(DEP)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_tag     (req_tag),
        .req_a       (req_a),
        .req_b       (req_b),
        .cmp_a       (cmp_a),
        .cmp_b       (cmp_b),
        .cmp_q       (cmp_q),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_tag    (resp_tag),
        .resp_result (resp_result)
    );

    // IEEE-754 equality: NaN never equal, +0 == -0.
    function automatic logic feq(input logic [31:0] a, input logic [31:0] b);
        logic na, nb;
        na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        if (na || nb) return 1'b0;
        if (((a | b) & 32'h7FFF_FFFF) == 0) return 1'b1;
        return a == b;
    endfunction

    // Comparator model, LATENCY=1, areset = !reset.
    always @(posedge clock or negedge reset) begin
        if (!reset) cmp_q <= 1'b0;
        else        cmp_q <= feq(cmp_a, cmp_b);
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard of {tag, result} in issue order.
    logic [TW:0] sbq[$];

    always @(negedge clock) begin
        if (reset) begin
            if (sbq.size() == 0) chk("stale_resp", resp_valid, 1'b0);
            else if (resp_valid && resp_ready) chk("resp_order", {resp_tag, resp_result}, sbq.pop_front());
            if (req_valid && req_ready) sbq.push_back({req_tag, feq(req_a, req_b) ^ req_op});
        end
    end

    task automatic send(input logic op, input logic [TW-1:0] tag, input logic [31:0] a, input logic [31:0] b);
        int k;
        req_valid = 1'b1; req_op = op; req_tag = tag; req_a = a; req_b = b;
        k = 0;
        @(negedge clock);
        while (!req_ready && k < 50) begin @(negedge clock); k++; end
        chk("send_timeout", k < 50, 1'b1);
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic expect_head(input string nm, input logic [TW-1:0] tag, input logic res);
        int k;
        k = 0;
        @(negedge clock);
        while (!resp_valid && k < 50) begin @(negedge clock); k++; end
        chk({nm, "_timeout"}, k < 50, 1'b1);
        chk({nm, "_tag"}, resp_tag, tag);
        chk({nm, "_result"}, resp_result, res);
        @(posedge clock); #1; resp_ready = 1'b1;
        @(posedge clock); #1; resp_ready = 1'b0;
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 50) begin @(posedge clock); #1; k++; end
        chk(nm, sbq.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, fourth;
        logic rr;
        logic [31:0] rv_hist;

        // Reset state
        #2 reset = 1'b0;
        @(negedge clock);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_resp_tag", resp_tag, '0);
        chk("rst_resp_result", resp_result, 1'b0);
        chk("rst_cmp_a", cmp_a, '0);
        chk("rst_cmp_b", cmp_b, '0);
        chk("rst_credits", dut.credits, DEP);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1;

        // 1: EQ 1.0 == 1.0, resp_valid sampled high at edge t+3
        req_valid = 1'b1; req_op = 1'b0; req_tag = 5'd3;
        req_a = 32'h3F80_0000; req_b = 32'h3F80_0000;
        @(negedge clock); chk("t1_ready", req_ready, 1'b1);
        @(posedge clock); #1 req_valid = 1'b0;
        @(negedge clock); chk("t1_rv_t1", resp_valid, 1'b0);
        @(negedge clock); chk("t1_rv_t2", resp_valid, 1'b0);
        @(negedge clock); chk("t1_rv_t3", resp_valid, 1'b1);
        chk("t1_tag", resp_tag, 5'd3);
        chk("t1_result", resp_result, 1'b1);
        @(posedge clock); #1 resp_ready = 1'b1;
        @(posedge clock); #1 resp_ready = 1'b0;

        // 2: NE +0 vs -0 -> 0 ; NE NaN vs NaN -> 1
        send(1'b1, 5'd7, 32'h0000_0000, 32'h8000_0000);
        send(1'b1, 5'd8, 32'h7FC0_0000, 32'h7FC0_0000);
        expect_head("t2_zero", 5'd7, 1'b0);
        expect_head("t2_nan", 5'd8, 1'b1);
        drain("t2_drain");

        // 3: backpressure, six offers, only DEPTH accepted
        acc = 0; fourth = -1;
        req_valid = 1'b1; req_op = 1'b0; req_a = 32'h4000_0000; req_b = 32'h4000_0000;
        req_tag = 5'd10;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            rr = req_ready;
            if (acc == 4 && fourth == c - 1) chk("t3_ready_low", rr, 1'b0);
            if (rr) begin acc++; if (acc == 4) fourth = c; end
            @(posedge clock); #1;
            if (rr) req_tag = req_tag + 1'b1;
        end
        req_valid = 1'b0;
        chk("t3_accepts", acc, 4);
        chk("t3_fourth_cycle", fourth, 3);
        @(posedge clock); #1 resp_ready = 1'b1;
        @(negedge clock); chk("t3_ready_prepop", req_ready, 1'b0);
        @(negedge clock); chk("t3_ready_postpop", req_ready, 1'b1);
        drain("t3_drain");

        // 4: streaming with resp_ready=1
        rv_hist = '0;
        for (int i = 0; i < 26; i++) begin
            if (i < 20) begin
                req_valid = 1'b1;
                req_op    = 1'((i / 2) % 2);
                req_tag   = TW'(i + 1);
                req_a     = 32'h3F80_0000 + 32'(i % 3);
                req_b     = 32'h3F80_0000 + 32'(i % 2);
                if (i == 7)  begin req_a = 32'h7FC0_0000; req_b = 32'h7FC0_0000; end
                if (i == 11) begin req_a = 32'h0000_0000; req_b = 32'h8000_0000; end
                if (i == 15) begin req_a = 32'h7F80_0000; req_b = 32'h7F80_0000; end
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clock);
            if (i < 20) chk("t4_ready", req_ready, 1'b1);
            rv_hist[i] = resp_valid;
            @(posedge clock); #1;
        end
        chk("t4_rv_pattern", rv_hist, 32'h007F_FFF8);
        drain("t4_drain");

        // 5: accept and pop together at credits=1
        resp_ready = 1'b0;
        send(1'b0, 5'd16, 32'h1, 32'h1);
        send(1'b1, 5'd17, 32'h1, 32'h2);
        send(1'b0, 5'd18, 32'h3, 32'h3);
        repeat (4) begin @(posedge clock); #1; end
        @(negedge clock);
        chk("t5_credits_pre", dut.credits, 1);
        chk("t5_head_valid", resp_valid, 1'b1);
        @(posedge clock); #1;
        req_valid = 1'b1; req_op = 1'b1; req_tag = 5'd20; req_a = 32'h5; req_b = 32'h6;
        resp_ready = 1'b1;
        @(negedge clock); chk("t5_ready_pre", req_ready, 1'b1);
        @(posedge clock); #1;
        req_valid = 1'b0; resp_ready = 1'b0;
        @(negedge clock);
        chk("t5_credits_post", dut.credits, 1);
        chk("t5_ready_post", req_ready, 1'b1);
        @(posedge clock); #1 resp_ready = 1'b1;
        drain("t5_drain");

        // 6: reset with two requests in flight
        resp_ready = 1'b0;
        send(1'b0, 5'd21, 32'h7, 32'h7);
        send(1'b0, 5'd22, 32'h8, 32'h8);
        reset = 1'b0;
        sbq.delete();
        @(negedge clock);
        chk("t6_resp_valid", resp_valid, 1'b0);
        chk("t6_req_ready", req_ready, 1'b1);
        chk("t6_credits", dut.credits, DEP);
        @(posedge clock); #1 reset = 1'b1; resp_ready = 1'b1;
        repeat (10) begin @(posedge clock); #1; end
        @(negedge clock);
        chk("t6_no_stale", resp_valid, 1'b0);
        chk("t6_credits_after", dut.credits, DEP);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
